// File: rtl/ddr4_dfi_init_seq.sv
// DDR4 power-up sequencer on the controller side of DFI.
// It sequences DRAM reset and CKE, runs the PHY init handshake, issues
// MR3,6,5,4,2,1,0 then ZQCL, and finally raises init_done.
// The wait states are sized so that the time from one command to the next
// event equals the programmed timing value.
module ddr4_dfi_init_seq #(
   parameter int RANKS     = 1,
   parameter int PHASES    = 4,
   parameter int CMD_PHASE = 0,
   parameter int A_WIDTH   = 17,
   parameter int BA_WIDTH  = 2,
   parameter int BG_WIDTH  = 2,
   parameter int CNT_WIDTH = 20,
   parameter int T_RESET   = 16,
   parameter int T_CKE     = 16,
   parameter int T_XPR     = 8,
   parameter int T_MRD     = 4,
   parameter int T_MOD     = 8,
   parameter int T_ZQINIT  = 32,
   parameter int T_TIMEOUT = 1024,
   parameter logic [A_WIDTH-1:0] MR0 = '0,
   parameter logic [A_WIDTH-1:0] MR1 = '0,
   parameter logic [A_WIDTH-1:0] MR2 = '0,
   parameter logic [A_WIDTH-1:0] MR3 = '0,
   parameter logic [A_WIDTH-1:0] MR4 = '0,
   parameter logic [A_WIDTH-1:0] MR5 = '0,
   parameter logic [A_WIDTH-1:0] MR6 = '0
) (
   input  logic                         dfi_clk,
   input  logic                         reset,
   input  logic                         restart,
   output logic                         dfi_init_start,
   input  logic                         dfi_init_complete,
   output logic [RANKS-1:0]             dfi_reset_n,
   output logic [RANKS*PHASES-1:0]      dfi_cke,
   output logic [RANKS*PHASES-1:0]      dfi_cs_n,
   output logic [PHASES-1:0]            dfi_act_n,
   output logic [PHASES-1:0]            dfi_ras_n,
   output logic [PHASES-1:0]            dfi_cas_n,
   output logic [PHASES-1:0]            dfi_we_n,
   output logic [PHASES*A_WIDTH-1:0]    dfi_address,
   output logic [PHASES*BA_WIDTH-1:0]   dfi_bank,
   output logic [PHASES*BG_WIDTH-1:0]   dfi_bg,
   output logic                         init_done,
   output logic                         init_error,
   output logic [3:0]                   init_state
);

   // Zero timings behave as one cycle.
   localparam int RST_N = (T_RESET  > 0) ? T_RESET  : 1;
   localparam int CKE_N = (T_CKE    > 0) ? T_CKE    : 1;
   localparam int XPR_N = (T_XPR    > 0) ? T_XPR    : 1;
   localparam int MRD_N = (T_MRD    > 0) ? T_MRD    : 1;
   localparam int MOD_N = (T_MOD    > 0) ? T_MOD    : 1;
   localparam int ZQ_N  = (T_ZQINIT > 0) ? T_ZQINIT : 1;
   localparam int TO_N  = (T_TIMEOUT > 0) ? T_TIMEOUT : 1;

   // Counter preloads; the one-cycle command itself is part of the gap.
   localparam logic [CNT_WIDTH-1:0] LD_RESET = CNT_WIDTH'(RST_N - 1);
   localparam logic [CNT_WIDTH-1:0] LD_CKE   = CNT_WIDTH'(CKE_N - 1);
   localparam logic [CNT_WIDTH-1:0] LD_TO    = CNT_WIDTH'(TO_N - 1);
   localparam logic [CNT_WIDTH-1:0] LD_XPR   = CNT_WIDTH'(XPR_N - 1);
   localparam logic [CNT_WIDTH-1:0] LD_MRD   = CNT_WIDTH'((MRD_N > 1) ? MRD_N - 2 : 0);
   localparam logic [CNT_WIDTH-1:0] LD_MOD   = CNT_WIDTH'((MOD_N > 1) ? MOD_N - 2 : 0);
   localparam logic [CNT_WIDTH-1:0] LD_ZQ    = CNT_WIDTH'((ZQ_N  > 1) ? ZQ_N  - 2 : 0);

   typedef enum logic [3:0] {
      ST_RST_LOW  = 4'd0,
      ST_CKE_LOW  = 4'd1,
      ST_PHY_INIT = 4'd2,
      ST_XPR      = 4'd3,
      ST_MRS      = 4'd4,
      ST_MRS_WAIT = 4'd5,
      ST_ZQCL     = 4'd6,
      ST_ZQ_WAIT  = 4'd7,
      ST_DONE     = 4'd8,
      ST_ERROR    = 4'd9
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic [2:0]             k_q, k_d;

   logic                   cke_on, start_d, done_d, error_d;
   logic [2:0]             mr_n;
   logic                   cmd_cs_n, cmd_act_n, cmd_ras_n, cmd_cas_n, cmd_we_n;
   logic [A_WIDTH-1:0]     cmd_addr;
   logic [BA_WIDTH-1:0]    cmd_ba;
   logic [BG_WIDTH-1:0]    cmd_bg;

   logic [RANKS-1:0]           reset_n_d, reset_n_q;
   logic [RANKS*PHASES-1:0]    cke_d, cke_q, cs_n_d, cs_n_q;
   logic [PHASES-1:0]          act_n_d, act_n_q, ras_n_d, ras_n_q;
   logic [PHASES-1:0]          cas_n_d, cas_n_q, we_n_d, we_n_q;
   logic [PHASES*A_WIDTH-1:0]  addr_d, addr_q;
   logic [PHASES*BA_WIDTH-1:0] ba_d, ba_q;
   logic [PHASES*BG_WIDTH-1:0] bg_d, bg_q;
   logic                       start_q, done_q, error_q;

   // JEDEC issue order: index k selects mode register n.
   function automatic logic [2:0] mr_num(input logic [2:0] idx);
      case (idx)
         3'd0:    mr_num = 3'd3;
         3'd1:    mr_num = 3'd6;
         3'd2:    mr_num = 3'd5;
         3'd3:    mr_num = 3'd4;
         3'd4:    mr_num = 3'd2;
         3'd5:    mr_num = 3'd1;
         default: mr_num = 3'd0;
      endcase
   endfunction

   function automatic logic [A_WIDTH-1:0] mr_val(input logic [2:0] n);
      case (n)
         3'd0:    mr_val = MR0;
         3'd1:    mr_val = MR1;
         3'd2:    mr_val = MR2;
         3'd3:    mr_val = MR3;
         3'd4:    mr_val = MR4;
         3'd5:    mr_val = MR5;
         3'd6:    mr_val = MR6;
         default: mr_val = '0;
      endcase
   endfunction

   // Next state, MR index and wait counter (reloaded on every state change).
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      cnt_d   = (cnt_q != '0) ? cnt_q - CNT_WIDTH'(1) : cnt_q;
      case (state_q)
         ST_RST_LOW:  if (cnt_q == '0) state_d = ST_CKE_LOW;
         ST_CKE_LOW:  if (cnt_q == '0) state_d = ST_PHY_INIT;
         ST_PHY_INIT: begin
            if (dfi_init_complete)                     state_d = ST_XPR;
            else if (T_TIMEOUT != 0 && cnt_q == '0)    state_d = ST_ERROR;
         end
         ST_XPR:      if (cnt_q == '0) state_d = ST_MRS;
         ST_MRS: begin
            if ((k_q == 3'd6) ? (MOD_N > 1) : (MRD_N > 1)) state_d = ST_MRS_WAIT;
            else if (k_q == 3'd6)                          state_d = ST_ZQCL;
            else                                           k_d     = k_q + 3'd1;
         end
         ST_MRS_WAIT: begin
            if (cnt_q == '0) begin
               if (k_q == 3'd6) state_d = ST_ZQCL;
               else begin
                  state_d = ST_MRS;
                  k_d     = k_q + 3'd1;
               end
            end
         end
         ST_ZQCL:     state_d = (ZQ_N > 1) ? ST_ZQ_WAIT : ST_DONE;
         ST_ZQ_WAIT:  if (cnt_q == '0) state_d = ST_DONE;
         ST_DONE, ST_ERROR: begin
            if (restart) begin
               state_d = ST_RST_LOW;
               k_d     = 3'd0;
            end
         end
         default:     state_d = ST_RST_LOW;
      endcase
      if (state_d != state_q) begin
         case (state_d)
            ST_RST_LOW:  cnt_d = LD_RESET;
            ST_CKE_LOW:  cnt_d = LD_CKE;
            ST_PHY_INIT: cnt_d = LD_TO;
            ST_XPR:      cnt_d = LD_XPR;
            ST_MRS_WAIT: cnt_d = (k_q == 3'd6) ? LD_MOD : LD_MRD;
            ST_ZQ_WAIT:  cnt_d = LD_ZQ;
            default:     cnt_d = '0;
         endcase
      end
   end

   // Output decode from the next state so the registered outputs track init_state.
   always_comb begin
      cke_on    = state_d inside {ST_XPR, ST_MRS, ST_MRS_WAIT, ST_ZQCL, ST_ZQ_WAIT, ST_DONE};
      start_d   = (state_d == ST_PHY_INIT);
      done_d    = (state_d == ST_DONE);
      error_d   = (state_d == ST_ERROR);
      reset_n_d = (state_d == ST_RST_LOW) ? '0 : '1;
      mr_n      = mr_num(k_d);
      cmd_cs_n  = 1'b1;
      cmd_act_n = 1'b1;
      cmd_ras_n = 1'b1;
      cmd_cas_n = 1'b1;
      cmd_we_n  = 1'b1;
      cmd_addr  = '0;
      cmd_ba    = '0;
      cmd_bg    = '0;
      case (state_d)
         ST_MRS: begin
            cmd_cs_n    = 1'b0;
            cmd_ras_n   = 1'b0;
            cmd_cas_n   = 1'b0;
            cmd_we_n    = 1'b0;
            cmd_addr    = mr_val(mr_n);
            cmd_ba[1:0] = mr_n[1:0];
            cmd_bg[0]   = mr_n[2];
         end
         ST_ZQCL: begin
            cmd_cs_n     = 1'b0;
            cmd_we_n     = 1'b0;
            cmd_addr[10] = 1'b1;
         end
         default: ;
      endcase
   end

   // Only CMD_PHASE carries the command; every other slot is DES.
   generate
      for (genvar gi = 0; gi < PHASES; gi++) begin : g_phase
         localparam bit IS_CMD = (gi == CMD_PHASE);
         assign cke_d[gi*RANKS +: RANKS]      = {RANKS{cke_on}};
         assign cs_n_d[gi*RANKS +: RANKS]     = IS_CMD ? {RANKS{cmd_cs_n}} : {RANKS{1'b1}};
         assign act_n_d[gi]                   = IS_CMD ? cmd_act_n : 1'b1;
         assign ras_n_d[gi]                   = IS_CMD ? cmd_ras_n : 1'b1;
         assign cas_n_d[gi]                   = IS_CMD ? cmd_cas_n : 1'b1;
         assign we_n_d[gi]                    = IS_CMD ? cmd_we_n  : 1'b1;
         assign addr_d[gi*A_WIDTH +: A_WIDTH] = IS_CMD ? cmd_addr : '0;
         assign ba_d[gi*BA_WIDTH +: BA_WIDTH] = IS_CMD ? cmd_ba   : '0;
         assign bg_d[gi*BG_WIDTH +: BG_WIDTH] = IS_CMD ? cmd_bg   : '0;
      end
   endgenerate

   // State and output registers with synchronous reset.
   always_ff @(posedge dfi_clk) begin
      if (reset) begin
         state_q   <= ST_RST_LOW;
         cnt_q     <= LD_RESET;
         k_q       <= 3'd0;
         reset_n_q <= '0;
         cke_q     <= '0;
         cs_n_q    <= '1;
         act_n_q   <= '1;
         ras_n_q   <= '1;
         cas_n_q   <= '1;
         we_n_q    <= '1;
         addr_q    <= '0;
         ba_q      <= '0;
         bg_q      <= '0;
         start_q   <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         k_q       <= k_d;
         reset_n_q <= reset_n_d;
         cke_q     <= cke_d;
         cs_n_q    <= cs_n_d;
         act_n_q   <= act_n_d;
         ras_n_q   <= ras_n_d;
         cas_n_q   <= cas_n_d;
         we_n_q    <= we_n_d;
         addr_q    <= addr_d;
         ba_q      <= ba_d;
         bg_q      <= bg_d;
         start_q   <= start_d;
         done_q    <= done_d;
         error_q   <= error_d;
      end
   end

   assign dfi_init_start = start_q;
   assign dfi_reset_n    = reset_n_q;
   assign dfi_cke        = cke_q;
   assign dfi_cs_n       = cs_n_q;
   assign dfi_act_n      = act_n_q;
   assign dfi_ras_n      = ras_n_q;
   assign dfi_cas_n      = cas_n_q;
   assign dfi_we_n       = we_n_q;
   assign dfi_address    = addr_q;
   assign dfi_bank       = ba_q;
   assign dfi_bg         = bg_q;
   assign init_done      = done_q;
   assign init_error     = error_q;
   assign init_state     = state_q;

endmodule

// File: tb/tb_ddr4_dfi_init_seq.sv
// Bench for ddr4_dfi_init_seq: two configurations, every cycle compared
// against an event timeline computed from the sequence timings.
module tb_ddr4_dfi_init_seq;

   localparam logic [16:0] MA0 = 17'h00D50, MA1 = 17'h00301, MA2 = 17'h00228;
   localparam logic [16:0] MA3 = 17'h00004, MA4 = 17'h01800, MA5 = 17'h00420;
   localparam logic [16:0] MA6 = 17'h00817, MX  = 17'h15A5A;

   logic dfi_clk = 1'b0;
   always #5 dfi_clk = ~dfi_clk;

   // instance A: default geometry and timings
   logic        a_reset, a_restart, a_complete, a_start, a_done, a_error;
   logic [0:0]  a_reset_n;
   logic [3:0]  a_cke, a_cs_n, a_act_n, a_ras_n, a_cas_n, a_we_n, a_state;
   logic [67:0] a_addr;
   logic [7:0]  a_bank, a_bg;
   // instance B: two ranks, two phases, command on phase 1, short timings
   logic        b_reset, b_restart, b_complete, b_start, b_done, b_error;
   logic [1:0]  b_reset_n, b_act_n, b_ras_n, b_cas_n, b_we_n;
   logic [3:0]  b_cke, b_cs_n, b_state, b_bank, b_bg;
   logic [33:0] b_addr;

   ddr4_dfi_init_seq #(
      .MR0(MA0), .MR1(MA1), .MR2(MA2), .MR3(MA3), .MR4(MA4), .MR5(MA5), .MR6(MA6)
   ) dut_a (
      .dfi_clk(dfi_clk), .reset(a_reset), .restart(a_restart),
      .dfi_init_start(a_start), .dfi_init_complete(a_complete),
      .dfi_reset_n(a_reset_n), .dfi_cke(a_cke), .dfi_cs_n(a_cs_n),
      .dfi_act_n(a_act_n), .dfi_ras_n(a_ras_n), .dfi_cas_n(a_cas_n), .dfi_we_n(a_we_n),
      .dfi_address(a_addr), .dfi_bank(a_bank), .dfi_bg(a_bg),
      .init_done(a_done), .init_error(a_error), .init_state(a_state)
   );

   ddr4_dfi_init_seq #(
      .RANKS(2), .PHASES(2), .CMD_PHASE(1),
      .T_RESET(5), .T_CKE(3), .T_XPR(0), .T_MRD(3), .T_MOD(5), .T_ZQINIT(10), .T_TIMEOUT(64),
      .MR0(MA0 ^ MX), .MR1(MA1 ^ MX), .MR2(MA2 ^ MX), .MR3(MA3 ^ MX),
      .MR4(MA4 ^ MX), .MR5(MA5 ^ MX), .MR6(MA6 ^ MX)
   ) dut_b (
      .dfi_clk(dfi_clk), .reset(b_reset), .restart(b_restart),
      .dfi_init_start(b_start), .dfi_init_complete(b_complete),
      .dfi_reset_n(b_reset_n), .dfi_cke(b_cke), .dfi_cs_n(b_cs_n),
      .dfi_act_n(b_act_n), .dfi_ras_n(b_ras_n), .dfi_cas_n(b_cas_n), .dfi_we_n(b_we_n),
      .dfi_address(b_addr), .dfi_bank(b_bank), .dfi_bg(b_bg),
      .init_done(b_done), .init_error(b_error), .init_state(b_state)
   );

   int checks = 0;
   int errors = 0;
   int ord[7] = '{3, 6, 5, 4, 2, 1, 0};
   int c_r, c_p, c_cp, c_tr, c_tc, c_tx, c_mrd, c_mod, c_zq, c_to, c_to_raw;

   task automatic set_cfg(input int sel);
      if (sel == 0) begin
         c_r = 1; c_p = 4; c_cp = 0; c_tr = 16; c_tc = 16; c_tx = 8;
         c_mrd = 4; c_mod = 8; c_zq = 32; c_to = 1024; c_to_raw = 1024;
      end else begin
         c_r = 2; c_p = 2; c_cp = 1; c_tr = 5; c_tc = 3; c_tx = 1;
         c_mrd = 3; c_mod = 5; c_zq = 10; c_to = 64; c_to_raw = 64;
      end
   endtask

   function automatic logic [16:0] mrv(input int sel, input int n);
      logic [16:0] v;
      case (n)
         0: v = MA0; 1: v = MA1; 2: v = MA2; 3: v = MA3;
         4: v = MA4; 5: v = MA5; default: v = MA6;
      endcase
      if (sel == 1) v = v ^ MX;
      return v;
   endfunction

   // Expected state at cycle t after reset/restart; kc = MRS index when st is MRS.
   function automatic int exp_state(input int t, input int cstart, output int kc);
      int t0, de, tm, tz;
      kc = 0;
      t0 = c_tr + c_tc;
      if (t < c_tr) return 0;
      if (t < t0) return 1;
      de = (cstart > t0) ? cstart - t0 : 0;
      if (c_to_raw != 0 && de >= c_to) return (t < t0 + c_to) ? 2 : 9;
      if (t <= t0 + de) return 2;
      tm = t0 + de + 1 + c_tx;
      if (t < tm) return 3;
      for (int k = 0; k < 7; k++) begin
         if (t == tm + k * c_mrd) begin
            kc = k;
            return 4;
         end
      end
      tz = tm + 6 * c_mrd + c_mod;
      if (t < tz) return 5;
      if (t == tz) return 6;
      if (t < tz + c_zq) return 7;
      return 8;
   endfunction

   task automatic step();
      @(posedge dfi_clk);
      #1;
   endtask

   task automatic drive(input int sel, input logic rst, input logic rs, input logic cp);
      if (sel == 0) begin
         a_reset = rst; a_restart = rs; a_complete = cp;
      end else begin
         b_reset = rst; b_restart = rs; b_complete = cp;
      end
   endtask

   task automatic check(input int sel, input int t, input int st, input int kc);
      logic [16:0]  e_stat, o_stat;
      logic [111:0] e_cmd, o_cmd;
      logic [7:0]   e_cs, e_ba, e_bg;
      logic [3:0]   e_act, e_ras, e_cas, e_we;
      logic [71:0]  e_addr;
      int           n, rmask, rpmask;
      rmask  = (1 << c_r) - 1;
      rpmask = (1 << (c_r * c_p)) - 1;
      e_stat = {4'(st), 2'((st == 0) ? 0 : rmask), 8'((st >= 3 && st <= 8) ? rpmask : 0),
                1'(st == 2), 1'(st == 8), 1'(st == 9)};
      e_cs   = 8'(rpmask);
      e_act  = 4'((1 << c_p) - 1);
      e_ras  = e_act; e_cas = e_act; e_we = e_act;
      e_addr = '0; e_ba = '0; e_bg = '0;
      if (st == 4 || st == 6) begin
         for (int r = 0; r < c_r; r++) e_cs[c_cp*c_r + r] = 1'b0;
         e_we[c_cp] = 1'b0;
         if (st == 4) begin
            n = ord[kc];
            e_ras[c_cp] = 1'b0;
            e_cas[c_cp] = 1'b0;
            e_addr[c_cp*17 +: 17] = mrv(sel, n);
            e_ba[c_cp*2 +: 2] = 2'(n & 3);
            e_bg[c_cp*2 +: 2] = 2'((n >> 2) & 1);
         end else begin
            e_addr[c_cp*17 + 10] = 1'b1;
         end
      end
      e_cmd = {e_cs, e_act, e_ras, e_cas, e_we, e_addr, e_ba, e_bg};
      if (sel == 0) begin
         o_stat = {a_state, 2'(a_reset_n), 8'(a_cke), a_start, a_done, a_error};
         o_cmd  = {8'(a_cs_n), a_act_n, a_ras_n, a_cas_n, a_we_n, 72'(a_addr), a_bank, a_bg};
      end else begin
         o_stat = {b_state, b_reset_n, 8'(b_cke), b_start, b_done, b_error};
         o_cmd  = {8'(b_cs_n), 4'(b_act_n), 4'(b_ras_n), 4'(b_cas_n), 4'(b_we_n),
                   72'(b_addr), 8'(b_bank), 8'(b_bg)};
      end
      checks++;
      assert (o_stat === e_stat) else begin
         errors++;
         $error("FAIL status sel=%0d t=%0d got %h exp %h", sel, t, o_stat, e_stat);
      end
      checks++;
      assert (o_cmd === e_cmd) else begin
         errors++;
         $error("FAIL cmdbus sel=%0d t=%0d got %h exp %h", sel, t, o_cmd, e_cmd);
      end
   endtask

   task automatic pulse_reset(input int sel);
      drive(sel, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
      step();
      drive(sel, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pulse_restart(input int sel);
      drive(sel, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
      step();
      drive(sel, 1'b0, 1'b0, 1'b0);
   endtask

   // One sequence from t=0; abort_k>=0 resets in MRS_WAIT after MRS index abort_k.
   task automatic run(input int sel, input int cstart, input int abort_k, input bit end_restart);
      int t0, de, tz, end_t, abort_t, st, kc;
      bit tmo;
      logic cp, rs;
      set_cfg(sel);
      t0      = c_tr + c_tc;
      de      = (cstart > t0) ? cstart - t0 : 0;
      tmo     = (c_to_raw != 0) && (de >= c_to);
      tz      = t0 + de + 1 + c_tx + 6 * c_mrd + c_mod;
      end_t   = tmo ? t0 + c_to + 3 : tz + c_zq + 3;
      abort_t = (abort_k >= 0 && !tmo) ? t0 + de + 1 + c_tx + abort_k * c_mrd + 1 : -1;
      $display("run sel=%0d cstart=%0d abort_k=%0d timeout=%0d restart_end=%0d",
               sel, cstart, abort_k, tmo, end_restart);
      for (int t = 0; t <= end_t; t++) begin
         st = exp_state(t, cstart, kc);
         check(sel, t, st, kc);
         if (t == abort_t) begin
            pulse_reset(sel);
            return;
         end
         if (t == end_t) begin
            if (end_restart) pulse_restart(sel);
            else             pulse_reset(sel);
            return;
         end
         cp = (st == 2) ? (t >= cstart) : 1'($urandom_range(0, 1));
         rs = (st == 8 || st == 9) ? 1'b0 : ((st == 3) ? 1'b1 : ($urandom_range(0, 5) == 0));
         drive(sel, 1'b0, rs, cp);
         step();
      end
   endtask

   initial begin
      a_reset = 1'b1; a_restart = 1'b0; a_complete = 1'b0;
      b_reset = 1'b1; b_restart = 1'b0; b_complete = 1'b0;
      step();
      step();
      pulse_reset(0);
      run(0, 32 + 5, -1, 1'b1);                          // nominal, then restart from DONE
      run(0, int'($urandom_range(0, 31)), -1, 1'b0);     // complete high before PHY_INIT
      run(0, 32 + int'($urandom_range(0, 20)), 2, 1'b0); // reset after MR5
      run(0, 32 + int'($urandom_range(0, 20)), -1, 1'b0);
      a_reset = 1'b1;
      pulse_reset(1);
      run(1, 100000, -1, 1'b1);                          // timeout, restart from ERROR
      run(1, 8 + 63, -1, 1'b1);                          // completes on last allowed cycle
      run(1, 8 + 64, -1, 1'b0);                          // one cycle late
      for (int i = 0; i < 4; i++) begin
         run(1, 8 + int'($urandom_range(0, 70)),
             ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : -1,
             1'($urandom_range(0, 1)));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
